pipe_hazard_scoreboard: RTL
===========================

// Module: pipe_hazard_scoreboard
// PURPOSE
//  Parametrised successor to the fixed 3-stage hazard detector. Sits beside ID:
//  - tracks in-flight register writes in a shift scoreboard sized by STAGES;
//  - raises data/PC stalls and runs a control-hazard FSM with a timeout;
//  - counts stall cycles;
//  - optionally selects operand forwarding instead of stalling.
// PARAMETERS
//  REG_AW       5   register address width (2**REG_AW regs, reg 0 hardwired zero)
//  STAGES       3   tracked stages after ID (0=IDEX, 1=EXMEM, 2=MEMWB, ...), >=2
//  CTRL_TIMEOUT 15  max cycles in WAIT_PC before ctrl_err
//  CNT_W        16  stall counter width
// PORTS
//  clk          in  1       clock, all state on rising edge
//  rst          in  1       asynchronous, active-low reset
//  id_valid     in  1       valid instruction in ID
//  rd1_addr     in  REG_AW  read port 1 address
//  rd1_en       in  1       read port 1 used
//  rd2_addr     in  REG_AW  read port 2 address
//  rd2_en       in  1       read port 2 used
//  id_dest      in  REG_AW  destination register of ID instruction
//  id_regwrite  in  1       ID instruction writes id_dest
//  id_load      in  1       result only available after MEM (stage>=2)
//  id_ctrl      in  1       ID instruction is call/ret/branch
//  pc_resolve   in  1       PC control has applied the PC update
//  flush        in  1       kill all tracked entries, abort WAIT_PC
//  data_hazard  out 1       stall IF/ID, bubble into IDEX
//  pc_hazard    out 1       control hazard pending
//  issue        out 1       ID instruction advances into IDEX this cycle
//  fwd_sel1     out SW      port 1 source: 0=regfile, k=stage k (SW=$clog2(STAGES+1))
//  fwd_sel2     out SW      port 2 source, same encoding
//  ctrl_err     out 1       sticky: WAIT_PC exceeded CTRL_TIMEOUT
//  stall_cnt    out CNT_W   saturating count of cycles with data_hazard|pc_hazard
// BEHAVIOUR
//  Reset (rst=0, async):
//   - all entries invalid, FSM=IDLE, ctrl_err=0, stall_cnt=0;
//   - outputs 0 (fwd_sel 0).
//  Scoreboard entry = {valid, dest, regwrite, load}. Every cycle:
//   - entry k moves to k+1; entry STAGES-1 retires;
//   - stage 0 loads the ID instruction if issue=1, else a bubble (valid=0).
//  Match (port p, stage k):
//   - rdp_en & valid[k] & regwrite[k] & dest[k]==rdp_addr & rdp_addr!=0.
//  data_hazard (combinational) = id_valid & any port has a stalling match.
//   - without FWD_EN every match stalls.
//  issue = id_valid & ~data_hazard & ~pc_hazard & ~flush.
//  Control FSM:
//   - IDLE: issue & id_ctrl -> WAIT_PC (tmr=0).
//   - WAIT_PC: pc_hazard=1, tmr++ per cycle.
//     - pc_resolve -> IDLE next cycle;
//     - tmr==CTRL_TIMEOUT -> ctrl_err<=1 and stay in WAIT_PC.
//   - pc_resolve in IDLE is ignored.
//  flush: next cycle all entries invalid and FSM=IDLE. flush wins over every
//   simultaneous event; ctrl_err is kept.
//  stall_cnt: +1 when data_hazard|pc_hazard; saturates at all-ones, no wrap.
//  Latency: hazard outputs are same-cycle combinational from inputs and state.
//   - A new entry is visible to compares one cycle after issue.
// CONFIGURATION
//  Macro PIPE_HAZARD_FWD_EN.
//  Defined:
//   - a match at stage k>=1 with load=0, or k>=2 with load=1, does not stall;
//   - fwd_selp = youngest (lowest k) such match;
//   - a match at stage 0, or a load at stage 1, stalls and forces fwd_selp=0.
//  Undefined: fwd_sel1/fwd_sel2 tied 0; every match stalls.
// TESTING
//  1. Reset mid-run with entries valid -> all outputs 0 immediately; stall_cnt=0.
//  2. Issue "add r3" then ID reads r3 (rd1_en=1), no FWD:
//     -> data_hazard=1 for 3 cycles, then issue=1.
//  3. Reads of r0 behind "add r0" -> data_hazard=0, fwd_sel=0.
//  4. FWD_EN: "lw r5" then read r5:
//     -> stall 2 cycles (stages 0 and 1), then issue with fwd_sel1=2.
//     "add r5" then read r5 -> stall 1 cycle, then fwd_sel1=1.
//  5. Branch issued, pc_resolve after 4 cycles:
//     -> pc_hazard=1 for 4 cycles, stall_cnt=4, FSM back to IDLE.
//     No resolve -> ctrl_err=1 after 15 cycles.
//  6. flush while in WAIT_PC with 3 valid entries -> next cycle pc_hazard=0,
//     data_hazard=0, and the pending read issues.

Source files
------------

// File: rtl/pipe_hazard_scoreboard_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_scoreboard_if
// Bundles the ID-stage view of the hazard scoreboard: the decoded operand and
// destination fields of the instruction sitting in ID, the PC-control
// handshake, and the stall / issue / forwarding results returned to ID.
//   master : the pipeline's ID stage (drives instruction fields, reads results)
//   slave  : the scoreboard itself
// Signals:
//   id_valid, rd1_addr/rd1_en, rd2_addr/rd2_en, id_dest, id_regwrite,
//   id_load, id_ctrl, pc_resolve, flush            (ID -> scoreboard)
//   data_hazard, pc_hazard, issue, fwd_sel1/2,
//   ctrl_err, stall_cnt                            (scoreboard -> ID)
// ---------------------------------------------------------------------------
interface pipe_hazard_scoreboard_if #(
    parameter int REG_AW = 5,
    parameter int STAGES = 3,
    parameter int CNT_W  = 16
);
    localparam int SW = $clog2(STAGES + 1);

    logic              id_valid;
    logic [REG_AW-1:0] rd1_addr;
    logic              rd1_en;
    logic [REG_AW-1:0] rd2_addr;
    logic              rd2_en;
    logic [REG_AW-1:0] id_dest;
    logic              id_regwrite;
    logic              id_load;
    logic              id_ctrl;
    logic              pc_resolve;
    logic              flush;

    logic              data_hazard;
    logic              pc_hazard;
    logic              issue;
    logic [SW-1:0]     fwd_sel1;
    logic [SW-1:0]     fwd_sel2;
    logic              ctrl_err;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, rd1_addr, rd1_en, rd2_addr, rd2_en, id_dest,
               id_regwrite, id_load, id_ctrl, pc_resolve, flush,
        input  data_hazard, pc_hazard, issue, fwd_sel1, fwd_sel2,
               ctrl_err, stall_cnt
    );

    modport slave (
        input  id_valid, rd1_addr, rd1_en, rd2_addr, rd2_en, id_dest,
               id_regwrite, id_load, id_ctrl, pc_resolve, flush,
        output data_hazard, pc_hazard, issue, fwd_sel1, fwd_sel2,
               ctrl_err, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// pipe_hazard_scoreboard
// Hazard unit beside ID. Tracks in-flight register writes in a STAGES-deep
// shift scoreboard, stalls ID on read-after-write dependences, holds ID while
// a control-transfer instruction waits for PC resolution (with a sticky
// timeout error), and counts stall cycles (saturating).
// Optional feature, macro PIPE_HAZARD_FWD_EN: ALU results at stage >=1 and
// load results at stage >=2 are forwarded instead of stalling; fwd_sel1/2
// name the youngest such stage. Without the macro every match stalls and
// fwd_sel1/2 are 0.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - asynchronous active-low reset
//   bus  - pipe_hazard_scoreboard_if.slave (ID fields in, hazard results out)
// Hazard/issue/forward outputs are combinational from inputs and state;
// ctrl_err and stall_cnt are registers.
// ---------------------------------------------------------------------------
module pipe_hazard_scoreboard #(
    parameter int REG_AW       = 5,
    parameter int STAGES       = 3,
    parameter int CTRL_TIMEOUT = 15,
    parameter int CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    pipe_hazard_scoreboard_if.slave bus
);
    localparam int SW = $clog2(STAGES + 1);
    localparam int TW = $clog2(CTRL_TIMEOUT + 1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_WAIT_PC = 1'b1
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [TW-1:0]     tmr_r, tmr_nxt_s;
    logic              ctrl_err_r, ctrl_err_nxt_s;
    logic [CNT_W-1:0]  stall_cnt_r;

    logic [STAGES-1:0] valid_r;
    logic [STAGES-1:0] regwrite_r;
    logic [STAGES-1:0] load_r;
    logic [REG_AW-1:0] dest_r [STAGES];

    logic [STAGES-1:0] match1_s, match2_s;
    logic [SW:0]       res1_s, res2_s;   // {stall, fwd_sel}
    logic              data_hazard_s, pc_hazard_s, issue_s;

`ifdef PIPE_HAZARD_FWD_EN
    // Youngest matching stage decides: it either forwards or, if its value
    // is not produced yet (stage 0, or a load still in stage 1), stalls.
    function automatic logic [SW:0] resolve_port(input logic [STAGES-1:0] m,
                                                 input logic [STAGES-1:0] ld);
        logic          found;
        logic          stall;
        logic [SW-1:0] sel;
        found = 1'b0;
        stall = 1'b0;
        sel   = {SW{1'b0}};
        for (int k = 0; k < STAGES; k++) begin
            if (m[k] && !found) begin
                found = 1'b1;
                if ((k == 0) || ((k == 1) && ld[k])) begin
                    stall = 1'b1;
                end else begin
                    sel = SW'(k);
                end
            end else begin
                found = found;
            end
        end
        return {stall, sel};
    endfunction
`else
    // No forwarding path: any in-flight write to a read register stalls.
    function automatic logic [SW:0] resolve_port(input logic [STAGES-1:0] m);
        return {|m, {SW{1'b0}}};
    endfunction

    // Load timing only matters when forwarding is built in.
    logic unused_s;
    assign unused_s = &{1'b0, bus.id_load, load_r};
`endif

    // Compare both read ports against every tracked stage
    always_comb begin
        match1_s = {STAGES{1'b0}};
        match2_s = {STAGES{1'b0}};
        for (int k = 0; k < STAGES; k++) begin
            match1_s[k] = bus.rd1_en & valid_r[k] & regwrite_r[k] &
                          (dest_r[k] == bus.rd1_addr) & (bus.rd1_addr != {REG_AW{1'b0}});
            match2_s[k] = bus.rd2_en & valid_r[k] & regwrite_r[k] &
                          (dest_r[k] == bus.rd2_addr) & (bus.rd2_addr != {REG_AW{1'b0}});
        end
    end

    // Per-port stall/forward decision and the issue condition
    always_comb begin
`ifdef PIPE_HAZARD_FWD_EN
        res1_s = resolve_port(match1_s, load_r);
        res2_s = resolve_port(match2_s, load_r);
`else
        res1_s = resolve_port(match1_s);
        res2_s = resolve_port(match2_s);
`endif
        data_hazard_s = bus.id_valid & (res1_s[SW] | res2_s[SW]);
        pc_hazard_s   = (state_r == ST_WAIT_PC);
        // Gating with rst keeps issue low while reset is held even if ID is valid.
        issue_s       = rst & bus.id_valid & ~data_hazard_s & ~pc_hazard_s & ~bus.flush;
    end

    assign bus.data_hazard = data_hazard_s;
    assign bus.pc_hazard   = pc_hazard_s;
    assign bus.issue       = issue_s;
    assign bus.fwd_sel1    = res1_s[SW-1:0];
    assign bus.fwd_sel2    = res2_s[SW-1:0];
    assign bus.ctrl_err    = ctrl_err_r;
    assign bus.stall_cnt   = stall_cnt_r;

    // Scoreboard shift: stage 0 takes the issuing instruction or a bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r    <= {STAGES{1'b0}};
            regwrite_r <= {STAGES{1'b0}};
            load_r     <= {STAGES{1'b0}};
            for (int k = 0; k < STAGES; k++) begin
                dest_r[k] <= {REG_AW{1'b0}};
            end
        end else if (bus.flush) begin
            valid_r <= {STAGES{1'b0}};
        end else begin
            valid_r    <= {valid_r[STAGES-2:0], issue_s};
            regwrite_r <= {regwrite_r[STAGES-2:0], bus.id_regwrite};
            load_r     <= {load_r[STAGES-2:0], bus.id_load};
            dest_r[0]  <= bus.id_dest;
            for (int k = 1; k < STAGES; k++) begin
                dest_r[k] <= dest_r[k-1];
            end
        end
    end

    // Control-hazard FSM state, wait timer and sticky timeout flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            tmr_r      <= {TW{1'b0}};
            ctrl_err_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            tmr_r      <= tmr_nxt_s;
            ctrl_err_r <= ctrl_err_nxt_s;
        end
    end

    // Control-hazard FSM next state; flush overrides everything but ctrl_err
    always_comb begin
        state_nxt_s    = state_r;
        tmr_nxt_s      = tmr_r;
        ctrl_err_nxt_s = ctrl_err_r;
        if (bus.flush) begin
            state_nxt_s = ST_IDLE;
            tmr_nxt_s   = {TW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (issue_s && bus.id_ctrl) begin
                        state_nxt_s = ST_WAIT_PC;
                        tmr_nxt_s   = {TW{1'b0}};
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_WAIT_PC: begin
                    if (bus.pc_resolve) begin
                        state_nxt_s = ST_IDLE;
                        tmr_nxt_s   = {TW{1'b0}};
                    end else if (tmr_r == TW'(CTRL_TIMEOUT)) begin
                        // Timer parks at the limit; keep waiting but flag it.
                        ctrl_err_nxt_s = 1'b1;
                    end else begin
                        tmr_nxt_s = tmr_r + {{(TW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    tmr_nxt_s   = {TW{1'b0}};
                end
            endcase
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if ((data_hazard_s || pc_hazard_s) && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end
endmodule
